// File: rtl/gt_rx_capture_if.sv
// Bus bundle for gt_rx_capture: GT RX data in, capture control, RAM readback and status out.
interface gt_rx_capture_if #(
  parameter int GT_CHN_NUM      = 6,
  parameter int USER_DATA_WIDTH = 32,
  parameter int RAM_DEPTH       = 1024
);
  localparam int AW = $clog2(RAM_DEPTH);

  logic [GT_CHN_NUM*USER_DATA_WIDTH-1:0] gt_data;
  logic                                  gt_data_valid;
  logic                                  reg_start;
  logic                                  reg_reset;
  logic [15:0]                           cap_len;
  logic [2:0]                            ram_idx;
  logic [AW-1:0]                         ram_addr;
  logic [USER_DATA_WIDTH-1:0]            ram_data;
  logic [GT_CHN_NUM-1:0]                 locked;
  logic                                  lock_lost;
  logic                                  busy;
  logic                                  cap_done;
  logic [15:0]                           err_cnt;

  modport master (
    output gt_data, gt_data_valid, reg_start, reg_reset, cap_len, ram_idx, ram_addr,
    input  ram_data, locked, lock_lost, busy, cap_done, err_cnt
  );
  modport slave (
    input  gt_data, gt_data_valid, reg_start, reg_reset, cap_len, ram_idx, ram_addr,
    output ram_data, locked, lock_lost, busy, cap_done, err_cnt
  );
endinterface

// File: rtl/gt_rx_capture.sv
// GT RX capture: per-channel sync-word lock, start-triggered capture into per-channel RAMs, readback.
// Optional ramp checker enabled by defining GT_RX_RAMP_CHK_EN.
module gt_rx_lane #(
  parameter int             W          = 32,
  parameter int             RAM_DEPTH  = 1024,
  parameter logic [W-1:0]   SYNC_WORD  = 32'hBC50_BC50,
  parameter int             LOCK_COUNT = 4,
  localparam int            AW         = $clog2(RAM_DEPTH)
) (
  input  logic          gt_clk,
  input  logic          srst,
  input  logic          valid,
  input  logic [W-1:0]  din,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
`ifdef GT_RX_RAMP_CHK_EN
  input  logic          ramp_chk,
  output logic          ramp_err,
`endif
  output logic          is_sync,
  output logic          locked,
  output logic [W-1:0]  rd_q
);
  localparam int CW = $clog2(LOCK_COUNT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          locked_q, locked_d;
  logic [W-1:0]  mem [RAM_DEPTH];

  assign is_sync = (din == SYNC_WORD);
  assign locked  = locked_q;

  // Counter saturates at LOCK_COUNT; once locked only the inverted sync word drops lock.
  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (cnt_q == CW'(LOCK_COUNT)) locked_d = 1'b1;
    if (valid) begin
      if (din == SYNC_WORD) begin
        if (cnt_q != CW'(LOCK_COUNT)) cnt_d = cnt_q + CW'(1);
      end else if (din == ~SYNC_WORD) begin
        cnt_d    = '0;
        locked_d = 1'b0;
      end else if (!locked_q) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge gt_clk) begin
    if (srst) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  // Block RAM: no reset on array or read register.
  always_ff @(posedge gt_clk) begin
    if (we) mem[waddr] <= din;
    rd_q <= mem[raddr];
  end

`ifdef GT_RX_RAMP_CHK_EN
  logic [W-1:0] prev_q, prev_d;
  always_comb begin
    prev_d   = we ? din : prev_q;
    ramp_err = ramp_chk && we && (din != prev_q + W'(1));
  end
  always_ff @(posedge gt_clk) begin
    if (srst) prev_q <= '0;
    else      prev_q <= prev_d;
  end
`endif
endmodule

module gt_rx_capture #(
  parameter int                         GT_CHN_NUM      = 6,
  parameter int                         USER_DATA_WIDTH = 32,
  parameter int                         RAM_DEPTH       = 1024,
  parameter logic [USER_DATA_WIDTH-1:0] SYNC_WORD       = 32'hBC50_BC50,
  parameter int                         LOCK_COUNT      = 4
) (
  input logic              gt_clk,
  input logic              gt_rstb,
  gt_rx_capture_if.slave   bus
);
  localparam int W  = USER_DATA_WIDTH;
  localparam int AW = $clog2(RAM_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_LOCK, WAIT_DATA, CAPTURE, DONE} state_e;

  state_e                        state_q, state_d;
  logic                          start_d1_q, edge_q, edge_d;
  logic [AW-1:0]                 wr_addr_q, wr_addr_d, last_q, last_d;
  logic                          cap_done_q, cap_done_d, lock_lost_q, lock_lost_d;
  logic [2:0]                    idx_q;
  logic [W-1:0]                  rdata_q, rdata_d;
  logic                          we, start_acc, srst;
  logic [GT_CHN_NUM-1:0]         is_sync, locked;
  logic [GT_CHN_NUM-1:0][W-1:0]  rd;

  assign srst   = !gt_rstb || bus.reg_reset;
  assign edge_d = bus.reg_start && !start_d1_q;

`ifdef GT_RX_RAMP_CHK_EN
  logic [GT_CHN_NUM-1:0] ramp_err;
  logic                  ramp_chk;
  assign ramp_chk = (state_q == CAPTURE);
`endif

  for (genvar n = 0; n < GT_CHN_NUM; n++) begin : g_lane
    gt_rx_lane #(.W(W), .RAM_DEPTH(RAM_DEPTH), .SYNC_WORD(SYNC_WORD), .LOCK_COUNT(LOCK_COUNT)) u_lane (
      .gt_clk   (gt_clk),
      .srst     (srst),
      .valid    (bus.gt_data_valid),
      .din      (bus.gt_data[n*W +: W]),
      .we       (we),
      .waddr    (wr_addr_q),
      .raddr    (bus.ram_addr),
`ifdef GT_RX_RAMP_CHK_EN
      .ramp_chk (ramp_chk),
      .ramp_err (ramp_err[n]),
`endif
      .is_sync  (is_sync[n]),
      .locked   (locked[n]),
      .rd_q     (rd[n])
    );
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    last_d      = last_q;
    cap_done_d  = cap_done_q;
    lock_lost_d = lock_lost_q;
    we          = 1'b0;
    start_acc   = 1'b0;
    case (state_q)
      IDLE, DONE: if (edge_q) begin
        start_acc   = 1'b1;
        cap_done_d  = 1'b0;
        lock_lost_d = 1'b0;
        wr_addr_d   = '0;
        last_d      = (int'(bus.cap_len) > RAM_DEPTH) ? AW'(RAM_DEPTH - 1) : AW'(bus.cap_len - 16'd1);
        if (bus.cap_len == 16'd0) begin
          state_d    = DONE;
          cap_done_d = 1'b1;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: if (&locked) state_d = WAIT_DATA;
      // First valid cycle free of sync words on every channel is word 0.
      WAIT_DATA: if (bus.gt_data_valid && !(|is_sync)) begin
        we = 1'b1;
        if (last_q == '0) begin
          state_d    = DONE;
          cap_done_d = 1'b1;
        end else begin
          state_d   = CAPTURE;
          wr_addr_d = wr_addr_q + AW'(1);
        end
      end
      CAPTURE: begin
        if (!(&locked)) lock_lost_d = 1'b1;
        if (bus.gt_data_valid) begin
          we = 1'b1;
          if (wr_addr_q == last_q) begin
            state_d    = DONE;
            cap_done_d = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (srst) we = 1'b0;
  end

  always_comb begin
    rdata_d = '0;
    for (int n = 0; n < GT_CHN_NUM; n++)
      if (idx_q == 3'(n)) rdata_d = rd[n];
  end

  always_ff @(posedge gt_clk) begin
    if (srst) begin
      state_q     <= IDLE;
      start_d1_q  <= bus.reg_start;
      edge_q      <= 1'b0;
      wr_addr_q   <= '0;
      last_q      <= '0;
      cap_done_q  <= 1'b0;
      lock_lost_q <= 1'b0;
      idx_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      start_d1_q  <= bus.reg_start;
      edge_q      <= edge_d;
      wr_addr_q   <= wr_addr_d;
      last_q      <= last_d;
      cap_done_q  <= cap_done_d;
      lock_lost_q <= lock_lost_d;
      idx_q       <= bus.ram_idx;
      rdata_q     <= rdata_d;
    end
  end

`ifdef GT_RX_RAMP_CHK_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  always_comb begin
    logic [16:0] sum;
    sum = {1'b0, err_cnt_q};
    for (int n = 0; n < GT_CHN_NUM; n++) sum = sum + 17'(ramp_err[n]);
    err_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    if (start_acc) err_cnt_d = '0;
  end
  always_ff @(posedge gt_clk) begin
    if (srst) err_cnt_q <= '0;
    else      err_cnt_q <= err_cnt_d;
  end
  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.ram_data  = rdata_q;
  assign bus.locked    = locked;
  assign bus.lock_lost = lock_lost_q;
  assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
  assign bus.cap_done  = cap_done_q;
endmodule

// File: tb/tb_gt_rx_capture.sv
// Directed bench for gt_rx_capture: lock, capture, gaps, edge lengths, lock loss, soft reset, ramp check.
module tb_gt_rx_capture;
  localparam logic [31:0] SYNC = 32'hBC50_BC50;
`ifdef GT_RX_RAMP_CHK_EN
  localparam logic [31:0] ERR_EXP = 32'd2;
`else
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  gt_rx_capture_if #(.GT_CHN_NUM(6), .USER_DATA_WIDTH(32), .RAM_DEPTH(1024)) bus ();
  gt_rx_capture dut (.gt_clk(clk), .gt_rstb(rstb), .bus(bus));

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [5:0][31:0] dw;
  logic [31:0] exp_mem [6][1024];
  logic [31:0] exp_q [$];
  int          wa, cap_lim, kk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v);
    bus.gt_data_valid = v;
    bus.gt_data       = dw;
  endtask

  task automatic syncs(input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 6; c++) dw[c] = SYNC;
      drive(1'b1);
      step();
    end
  endtask

  task automatic ramp(input int k);
    for (int c = 0; c < 6; c++) dw[c] = 32'(c) * 32'h1000 + 32'(k);
  endtask

  // Record the current word set as the next captured entry in the model.
  task automatic record();
    if (wa < cap_lim) for (int c = 0; c < 6; c++) exp_mem[c][wa] = dw[c];
    wa++;
  endtask

  task automatic send(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        for (int c = 0; c < 6; c++) dw[c] = 32'h0BAD_0000 + 32'(i);
        drive(1'b0);
        step();
      end
      ramp(kk);
      record();
      drive(1'b1);
      kk++;
      step();
    end
  endtask

  // Start with sync on the wire: edge, WAIT_LOCK, WAIT_DATA, one idle sync in WAIT_DATA.
  task automatic start_cap(input int len);
    bus.cap_len   = 16'(len);
    bus.reg_start = 1'b1;
    syncs(1);
    bus.reg_start = 1'b0;
    syncs(1);
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_done_clr", 32'(bus.cap_done), 32'd0);
    syncs(2);
    wa      = 0;
    cap_lim = (len > 1024) ? 1024 : len;
  endtask

  task automatic rd_burst(input int ch, input int a0, input int n, input string tag);
    logic [31:0] e;
    bus.gt_data_valid = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.ram_idx  = 3'(ch);
        bus.ram_addr = 10'(a0 + i);
        exp_q.push_back((ch < 6) ? exp_mem[ch][a0 + i] : 32'h0);
      end
      step();
      if (i >= 1) begin
        e = exp_q.pop_front();
        chk(tag, bus.ram_data, e);
      end
    end
  endtask

  initial begin
    dw = '0;
    bus.gt_data = '0; bus.gt_data_valid = 1'b0; bus.reg_start = 1'b0; bus.reg_reset = 1'b0;
    bus.cap_len = '0; bus.ram_idx = '0; bus.ram_addr = '0;
    kk = 0; wa = 0; cap_lim = 0;

    // Reset state
    repeat (3) step();
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.cap_done), 32'd0);
    chk("rst_lost", 32'(bus.lock_lost), 32'd0);
    chk("rst_err", 32'(bus.err_cnt), 32'd0);
    chk("rst_rdata", bus.ram_data, 32'd0);
    rstb = 1'b1;

    // Lock and 8-word capture; start armed before the link syncs
    bus.cap_len = 16'd8;
    bus.reg_start = 1'b1;
    step();
    bus.reg_start = 1'b0;
    step();
    chk("t1_busy_wait", 32'(bus.busy), 32'd1);
    syncs(4);
    chk("t1_not_yet_locked", 32'(bus.locked), 32'h00);
    syncs(1);
    chk("t1_locked", 32'(bus.locked), 32'h3F);
    syncs(1);
    wa = 0; cap_lim = 8; kk = 0;
    send(7, 1'b0);
    chk("t1_done_early", 32'(bus.cap_done), 32'd0);
    send(1, 1'b0);
    chk("t1_done", 32'(bus.cap_done), 32'd1);
    chk("t1_idle", 32'(bus.busy), 32'd0);
    rd_burst(2, 0, 8, "t1_rd_ch2");
    chk("t1_rd_2_7", bus.ram_data, 32'h2007);
    rd_burst(5, 0, 8, "t1_rd_ch5");
    rd_burst(6, 0, 1, "t1_rd_idx6");
    rd_burst(7, 3, 1, "t1_rd_idx7");
    chk("t1_lost", 32'(bus.lock_lost), 32'd0);

    // Valid gaps, 16 words
    start_cap(16);
    kk = 32'h100;
    send(15, 1'b1);
    chk("t2_done_early", 32'(bus.cap_done), 32'd0);
    send(1, 1'b1);
    chk("t2_done", 32'(bus.cap_done), 32'd1);
    rd_burst(1, 0, 16, "t2_rd_ch1");

    // Soft reset then cap_len=0: RAM untouched
    bus.reg_reset = 1'b1;
    step();
    bus.reg_reset = 1'b0;
    chk("t3_rst_done", 32'(bus.cap_done), 32'd0);
    chk("t3_rst_locked", 32'(bus.locked), 32'd0);
    bus.cap_len = 16'd0;
    bus.reg_start = 1'b1;
    step();
    bus.reg_start = 1'b0;
    chk("t3_zero_pending", 32'(bus.cap_done), 32'd0);
    step();
    chk("t3_zero_done", 32'(bus.cap_done), 32'd1);
    chk("t3_zero_idle", 32'(bus.busy), 32'd0);
    rd_burst(3, 0, 16, "t3_rd_ch3");

    // cap_len beyond RAM depth stops at 1024
    syncs(6);
    chk("t4_relocked", 32'(bus.locked), 32'h3F);
    start_cap(5000);
    kk = 0;
    send(1023, 1'b0);
    chk("t4_done_early", 32'(bus.cap_done), 32'd0);
    send(1, 1'b0);
    chk("t4_done", 32'(bus.cap_done), 32'd1);
    send(5, 1'b0);
    chk("t4_idle", 32'(bus.busy), 32'd0);
    rd_burst(5, 1020, 4, "t4_rd_tail");
    rd_burst(0, 0, 2, "t4_rd_head");

    // Soft reset mid-capture
    start_cap(16);
    kk = 32'h300;
    send(5, 1'b0);
    chk("t5_busy", 32'(bus.busy), 32'd1);
    bus.gt_data_valid = 1'b0;
    bus.reg_reset = 1'b1;
    step();
    bus.reg_reset = 1'b0;
    chk("t5_busy_clr", 32'(bus.busy), 32'd0);
    chk("t5_done_clr", 32'(bus.cap_done), 32'd0);
    chk("t5_locked_clr", 32'(bus.locked), 32'd0);
    rd_burst(1, 0, 7, "t5_rd_ch1");

    // Lock loss on channel 4 mid-capture
    syncs(6);
    start_cap(8);
    kk = 32'h400;
    send(3, 1'b0);
    ramp(kk);
    dw[4] = ~SYNC;
    record();
    drive(1'b1);
    kk++;
    step();
    send(4, 1'b0);
    chk("t6_done", 32'(bus.cap_done), 32'd1);
    chk("t6_lost", 32'(bus.lock_lost), 32'd1);
    chk("t6_locked", 32'(bus.locked), 32'h2F);
    chk("t6_err", 32'(bus.err_cnt), ERR_EXP);
    rd_burst(4, 0, 8, "t6_rd_ch4");

    // New start waits for channel 4 to relock; then ramp corruption on channels 0/1
    bus.cap_len = 16'd4;
    bus.reg_start = 1'b1;
    for (int c = 0; c < 6; c++) dw[c] = 32'h0000_1234;
    drive(1'b1);
    step();
    bus.reg_start = 1'b0;
    repeat (6) step();
    chk("t7_wait_busy", 32'(bus.busy), 32'd1);
    chk("t7_wait_done", 32'(bus.cap_done), 32'd0);
    chk("t7_lost_clr", 32'(bus.lock_lost), 32'd0);
    chk("t7_err_clr", 32'(bus.err_cnt), 32'd0);
    chk("t7_locked", 32'(bus.locked), 32'h2F);
    syncs(6);
    chk("t7_relocked", 32'(bus.locked), 32'h3F);
    wa = 0; cap_lim = 4; kk = 32'h500;
    send(3, 1'b0);
    ramp(kk);
    dw[0] = dw[0] ^ 32'h8000_0000;
    dw[1] = dw[1] ^ 32'h8000_0000;
    record();
    drive(1'b1);
    step();
    chk("t7_done", 32'(bus.cap_done), 32'd1);
    chk("t7_err", 32'(bus.err_cnt), ERR_EXP);
    rd_burst(0, 0, 4, "t7_rd_ch0");
    rd_burst(1, 0, 4, "t7_rd_ch1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gt_rx_capture.md
Name: gt_rx_capture

Overview:
- Receive-side counterpart to the GTY TX data path.
- Takes the parallel user data from all GT RX channels and checks per-channel lock on a sync word.
- On a software start, captures a programmed number of words per channel into internal RAMs.
- Software reads the RAMs back word by word over the register map (channel index plus address). Everything runs in the GT user clock domain; CDC to the AXI-Lite register block is handled outside this block.

Parameters:
- GT_CHN_NUM, 6: number of GT RX channels.
- USER_DATA_WIDTH, 32: bits per channel per clock.
- RAM_DEPTH, 1024: capture words per channel (power of 2).
- SYNC_WORD, 32'hBC50_BC50: idle/sync pattern the link transmits before payload.
- LOCK_COUNT, 4: consecutive SYNC_WORDs required to declare a channel locked.

Ports:
- gt_clk, in, 1: GT user clock; all logic on its rising edge.
- gt_rstb, in, 1: reset, synchronous, active-low.
- gt_data, in, GT_CHN_NUM*USER_DATA_WIDTH: RX data, channel n at bits [n*W +: W].
- gt_data_valid, in, 1: qualifies gt_data for the current cycle.
- reg_start, in, 1: level; rising edge arms a capture.
- reg_reset, in, 1: synchronous soft reset, active-high.
- cap_len, in, 16: words to capture per channel.
- ram_idx, in, 3: channel selected for readback.
- ram_addr, in, $clog2(RAM_DEPTH): readback address.
- ram_data, out, USER_DATA_WIDTH: readback data.
- locked, out, GT_CHN_NUM: per-channel lock status.
- lock_lost, out, 1: sticky; some channel lost lock during CAPTURE.
- busy, out, 1: state is not IDLE and not DONE.
- cap_done, out, 1: sticky; capture complete.
- err_cnt, out, 16: ramp-check error count (optional feature).

Behaviour:
- **Reset and priority:** reset is synchronous, active-low on gt_rstb. reg_reset has the same effect, except RAM contents are not cleared. While either reset is active, all outputs go to 0 and state goes to IDLE; reset takes priority over every other event, including mid-capture.
- **Lock, per channel:**
  - Counter increments on each valid word equal to SYNC_WORD.
  - Counter clears on any valid non-SYNC_WORD word while unlocked.
  - locked[n] sets the cycle after the counter reaches LOCK_COUNT.
  - Once locked, locked[n] clears only on a valid word equal to ~SYNC_WORD (loss marker) or on reset.
  - Cycles with gt_data_valid low leave the counters unchanged.
- **Start detect:** rising edge of reg_start, registered. Edges seen in any state other than IDLE or DONE are ignored.
- **Capture length:** eff_len = min(cap_len, RAM_DEPTH), latched at start.
- **FSM:**
  - IDLE: on start edge, go to WAIT_LOCK if eff_len != 0. If eff_len == 0, go straight to DONE with cap_done=1 and no RAM writes.
  - WAIT_LOCK: wait until locked is all ones, then go to WAIT_DATA.
  - WAIT_DATA: on the first valid cycle where no channel carries SYNC_WORD, write that cycle at address 0 and go to CAPTURE. This cycle is the first captured word.
  - CAPTURE: each valid cycle writes all channels' words at wr_addr, then increments wr_addr. When wr_addr == eff_len-1 is written, go to DONE. Invalid cycles write nothing and hold the address.
  - DONE: cap_done=1. A new start edge clears cap_done and lock_lost, resets wr_addr to 0, and proceeds exactly as from IDLE.
- **Lock loss during CAPTURE:** the capture continues and lock_lost sets, sticky. A start edge or reset clears it.
- **RAMs:** GT_CHN_NUM simple dual-port RAMs, RAM_DEPTH x W each, inferred as block RAM.
- **Readback:** ram_data is valid 2 cycles after ram_addr/ram_idx (registered RAM read, then registered channel mux). ram_idx >= GT_CHN_NUM returns 0. Reading is allowed in any state.

Optional Feature:
- Macro: GT_RX_RAMP_CHK_EN.
- When defined, during CAPTURE each channel checks that every valid word equals the previous captured word + 1, mod 2^W. The first word of a capture is not checked.
- err_cnt increments by the number of mismatching channels in that cycle and saturates at 16'hFFFF. It is cleared by a start edge or reset.
- When not defined, err_cnt is constant 0 and no checker logic is built.

Test Plan:
- **Lock and capture:** drive 4 x SYNC_WORD on all channels, then ramps (channel n starts at n*16'h1000), with cap_len=8 and a start pulse. Expect locked=6'h3F after the 4th sync plus 1 cycle, cap_done=1, and readback of idx 2, addr 7 = 32'h2007 with 2-cycle latency.
- **Valid gaps:** toggle gt_data_valid 1/0 during capture with cap_len=16. Expect exactly 16 words stored with no gaps or duplicates, and cap_done only after the 16th valid word.
- **Edge lengths:**
  - cap_len=0: cap_done=1 within 2 cycles of start and the RAM is unchanged.
  - cap_len=5000: capture stops at 1024 words.
- **Lock loss mid-capture:** inject ~SYNC_WORD on channel 4 mid-capture. Expect locked[4]=0, lock_lost=1, and the capture still completing. A new start waits in WAIT_LOCK until channel 4 relocks.
- **Soft reset mid-capture:** assert reg_reset mid-capture. Expect busy=0, cap_done=0, locked=0 on the next cycle, and earlier RAM words still readable.
- **Ramp check (GT_RX_RAMP_CHK_EN):** corrupt one word on channels 0 and 1 in the same cycle. Expect err_cnt=2; with the macro undefined, err_cnt=0.
